// File: rtl/hw5_result_buffer.sv
// hw5_result_buffer: FIFO that holds ALU pipeline results {result, tag, op}
// until a downstream consumer accepts them with a valid/ready handshake.
// NOP ops are filtered out. A push into a full buffer with no same-edge pop
// is dropped and sets a sticky overflow flag.
// Optional feature: define HW5_RESULT_BUFFER_DROP_COUNT_EN to add a 16-bit
// saturating drop_count output.
module hw5_result_buffer #(
  parameter int WIDTH    = 32,
  parameter int DATABITS = 7,
  parameter int DEPTH    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_result,
  input  logic [DATABITS-1:0]        in_tag,
  input  logic [1:0]                 in_op,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_result,
  output logic [DATABITS-1:0]        out_tag,
  output logic [1:0]                 out_op,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow
`ifdef HW5_RESULT_BUFFER_DROP_COUNT_EN
  ,
  output logic [15:0]                drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = WIDTH + DATABITS + 2;
  localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  // Storage holds packed {result, tag, op}; it needs no reset value because
  // only entries below count are ever presented.
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [EW-1:0] head;

  logic op_valid;
  logic pop;
  logic push;
  logic drop;

  // Handshake decode: a pop frees a slot in the same edge, so a full buffer
  // can still accept a push when the head is leaving.
  always_comb begin
    op_valid = (in_op != 2'd0);
    pop      = out_valid && out_ready;
    push     = op_valid && (!full || pop);
    drop     = op_valid && full && !pop;
  end

  // Head presentation comes only from registered state, so nothing pushed
  // this cycle can appear on the outputs before the next edge.
  always_comb begin
    head       = mem[rd_ptr];
    out_valid  = (count != '0);
    full       = (count == FULL_CNT);
    out_result = '0;
    out_tag    = '0;
    out_op     = '0;
    if (out_valid) begin
      out_result = head[EW-1 -: WIDTH];
      out_tag    = head[DATABITS+1 -: DATABITS];
      out_op     = head[1:0];
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_result, in_tag, in_op};
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef HW5_RESULT_BUFFER_DROP_COUNT_EN
  // Saturating count of dropped pushes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (drop && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/hw5_result_buffer.md
HW5_RESULT_BUFFER -- requirements
Module: hw5_result_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the ALU result width.
REQ-002 The block SHALL have parameter DATABITS, default 7, giving the tag width.
REQ-003 The block SHALL have parameter DEPTH, default 8, giving the entry count; DEPTH SHALL be a power of two and at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_result, input, WIDTH bits: the ALU pipeline result.
REQ-007 The block SHALL have port in_tag, input, DATABITS bits: the ALU pipeline tag.
REQ-008 The block SHALL have port in_op, input, 2 bits: the ALU op, where 0=NOP, 1=ADD, 2=SUB and 3=MULT.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the head entry.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the head entry is present.
REQ-011 The block SHALL have ports out_result (WIDTH bits), out_tag (DATABITS bits) and out_op (2 bits), all outputs: the head entry fields.
REQ-012 The block SHALL have port count, output, log2(DEPTH)+1 bits: the occupancy.
REQ-013 The block SHALL have port full, output, 1 bit: high when count equals DEPTH.
REQ-014 The block SHALL have port overflow, output, 1 bit: a sticky flag for a dropped result.

Function
REQ-015 A push SHALL occur on a clk edge when in_op is not 0 and the buffer has room, where room means not full, or full with a pop on the same edge.
REQ-016 A clk edge with in_op equal to 0 SHALL NOT push.
REQ-017 A pop SHALL occur on a clk edge when out_valid and out_ready are both 1.
REQ-018 A push when full without a same-edge pop SHALL drop the entry, leave count unchanged and set overflow to 1.
REQ-019 Entries SHALL leave in FIFO order with {result, tag, op} unmodified.
REQ-020 Write and read pointers SHALL wrap from DEPTH-1 to 0.
REQ-021 A push and pop on the same edge SHALL leave count unchanged and is legal when full.
REQ-022 A push and pop on the same edge while count is 1 SHALL present the new entry as head after the edge.
REQ-023 The buffer SHALL have no bypass path: an entry pushed at edge N SHALL be visible on out_* with out_valid=1 only after edge N, giving 1-cycle latency.
REQ-024 When the buffer is empty, a simultaneous push SHALL NOT produce out_valid in the same cycle.
REQ-025 out_valid SHALL equal (count != 0), decoded from registered state.
REQ-026 out_result, out_tag and out_op SHALL be forced to 0 whenever out_valid is 0.
REQ-027 out_ready asserted while out_valid is 0 SHALL have no effect.
REQ-028 overflow SHALL clear only on reset.

Reset
REQ-029 Asserting reset low SHALL immediately clear the pointers, count, full and overflow, and SHALL force out_valid, out_result, out_tag and out_op to 0, independent of clk.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries, with no entry visible after release.
REQ-031 The first push after reset release SHALL occur on the first rising clk edge at which reset is high.
REQ-032 Storage array contents SHALL NOT require a reset value.

Configuration
REQ-033 When the macro HW5_RESULT_BUFFER_DROP_COUNT_EN is defined, the block SHALL add output drop_count (16 bits).
REQ-034 drop_count SHALL increment on each dropped push, SHALL saturate at 65535 and SHALL reset to 0.
REQ-035 When the macro HW5_RESULT_BUFFER_DROP_COUNT_EN is undefined, the drop_count port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-036 Reset check: hold reset=0, then release -> out_valid=0, count=0, full=0, overflow=0 and out_*=0.
REQ-037 Single entry: push {result=0x0000_0007, tag=5, op=1} with out_ready=0 -> one cycle later out_valid=1, out_result=7, out_tag=5, out_op=1 and count=1; then set out_ready=1 -> next cycle out_valid=0.
REQ-038 NOP filtering: 4 cycles with in_op=0 and arbitrary data -> count stays 0.
REQ-039 Fill, overflow and wrap (DEPTH=8): push tags 0..8 with out_ready=0 -> count=8, full=1, overflow=1, tag 8 dropped (drop_count=1 with the macro defined); drain -> tags 0..7 out in order; refill 3 entries -> pointers wrap and order is preserved.
REQ-040 Full push+pop: when full, push tag 9 while popping -> count stays 8, overflow does not newly set, and tag 9 exits last.
REQ-041 Reset mid-stream: with 5 entries stored, pulse reset=0 between clk edges -> count=0 and out_valid=0 immediately, with no stale entry after release.
